// File: rtl/vga_cmd_sched_pkg.sv
// ----------------------------------------------------------------------------
// vga_cmd_sched_pkg
// Shared definitions for the VGA command scheduler: command type codes,
// table field codes, one-hot table selects, FSM state encoding and the
// small decode helpers used by the scheduler.
// ----------------------------------------------------------------------------
package vga_cmd_sched_pkg;

    // Command type as presented by the execute stage.
    typedef enum logic [1:0] {
        CMD_SPRITE = 2'b00,
        CMD_FONT   = 2'b01,
        CMD_BG     = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_type_e;

    // Low two bits of the table address select the field inside an entry.
    localparam logic [1:0] FLD_POS  = 2'b00;
    localparam logic [1:0] FLD_ATTR = 2'b01;
    localparam logic [1:0] FLD_VISI = 2'b10;
    localparam logic [1:0] FLD_NONE = 2'b11;

    // One-hot table select, bit order {background, font, sprite}.
    localparam logic [2:0] SEL_NONE   = 3'b000;
    localparam logic [2:0] SEL_SPRITE = 3'b001;
    localparam logic [2:0] SEL_FONT   = 3'b010;
    localparam logic [2:0] SEL_BG     = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    // Field flags arrive as {pos, attr, visi}; multi-hot resolves pos > attr > visi.
    function automatic logic [1:0] field_code(input logic [2:0] field);
        if (field[2])      return FLD_POS;
        else if (field[1]) return FLD_ATTR;
        else if (field[0]) return FLD_VISI;
        else               return FLD_NONE;
    endfunction

    function automatic logic [2:0] tbl_sel_of(input logic [1:0] cmd_type);
        case (cmd_type)
            CMD_SPRITE: return SEL_SPRITE;
            CMD_FONT:   return SEL_FONT;
            CMD_BG:     return SEL_BG;
            default:    return SEL_NONE;
        endcase
    endfunction

    // Tables are free when the display is not reading them; in blank-only
    // builds the display must also be in blanking.
    function automatic logic win_open(input logic vid_rd, input logic vid_blank,
                                      input logic blank_only);
        return ~vid_rd & (vid_blank | ~blank_only);
    endfunction

endpackage

// File: rtl/vga_cmd_sched_if.sv
// ----------------------------------------------------------------------------
// vga_cmd_sched_if
// Command-in / table-write-out signal bundle of the VGA command scheduler.
//   cmd_*   : execute-stage command and the stall returned to the pipeline
//   tbl_*   : table write request (we/sel/addr/wdata) and its grant
// Modports:
//   slave  - the scheduler (consumes commands, issues table writes)
//   master - the surrounding pipeline / table arbiter
// ----------------------------------------------------------------------------
interface vga_cmd_sched_if #(
    parameter int IDX_W = 6
);
    logic             cmd_valid;
    logic [1:0]       cmd_type;
    logic [2:0]       cmd_field;
    logic [IDX_W-1:0] cmd_index;
    logic [31:0]      cmd_data;
    logic             cmd_stall;

    logic             tbl_we;
    logic             tbl_gnt;
    logic [2:0]       tbl_sel;
    logic [IDX_W+1:0] tbl_addr;
    logic [31:0]      tbl_wdata;

    modport slave (
        input  cmd_valid, cmd_type, cmd_field, cmd_index, cmd_data, tbl_gnt,
        output cmd_stall, tbl_we, tbl_sel, tbl_addr, tbl_wdata
    );

    modport master (
        output cmd_valid, cmd_type, cmd_field, cmd_index, cmd_data, tbl_gnt,
        input  cmd_stall, tbl_we, tbl_sel, tbl_addr, tbl_wdata
    );
endinterface

// File: rtl/vga_cmd_fifo.sv
// ----------------------------------------------------------------------------
// vga_cmd_fifo
// Command queue for the VGA scheduler: DEPTH entries of WIDTH bits, show-ahead
// head output, synchronous clear.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   i_push, i_din  - enqueue (ignored when full or while clearing)
//   i_pop          - dequeue head (ignored when empty or while clearing)
//   i_clr          - empty the queue on the next edge
//   o_dout         - current head entry
//   o_full, o_empty, o_count - occupancy status (from registered count)
// ----------------------------------------------------------------------------
module vga_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 43
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clr,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = 1;
    localparam logic [AW:0]     CNT_ONE  = 1;
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full  & ~i_clr;
    assign w_pop  = i_pop  & ~o_empty & ~i_clr;

    // NOTE: storage has no reset; validity is tracked by pointers/count, and
    // leaving it out keeps the array mappable to plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/vga_cmd_sched.sv
// ----------------------------------------------------------------------------
// vga_cmd_sched
// Queues sprite/font/background table writes from the execute stage and
// issues them, in order, only while the display is not reading the tables.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   bus (slave)  - cmd_valid/type/field/index/data in, cmd_stall out;
//                  tbl_we/sel/addr/wdata out, tbl_gnt in
//   clr          - synchronous queue clear
//   vid_rd       - display reads the tables this cycle (closes the window)
//   vid_blank    - display in blanking
//   busy         - queue non-empty or a write pending
//   q_count      - queue occupancy
// Build option: define VGA_SCHED_BLANK_ONLY_EN to also require vid_blank=1
// for the write window; otherwise vid_blank has no effect.
// ----------------------------------------------------------------------------
module vga_cmd_sched
    import vga_cmd_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    vga_cmd_sched_if.slave         bus,
    input  logic                   clr,
    input  logic                   vid_rd,
    input  logic                   vid_blank,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count
);
`ifdef VGA_SCHED_BLANK_ONLY_EN
    localparam logic BLANK_ONLY = 1'b1;
`else
    localparam logic BLANK_ONLY = 1'b0;
`endif
    localparam int ENTRY_W = 2 + 3 + IDX_W + 32;

    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic               w_full;
    logic               w_empty;
    logic               w_win;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_head;
    logic [1:0]         w_head_type;
    logic [2:0]         w_head_field;
    logic [IDX_W-1:0]   w_head_index;
    logic [31:0]        w_head_data;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2:0]         r_sel;
    logic [IDX_W+1:0]   r_addr;
    logic [31:0]        r_wdata;

    assign w_push = bus.cmd_valid & ~w_full & ~clr & (bus.cmd_type != CMD_RSVD);
    assign w_din  = {bus.cmd_type, bus.cmd_field, bus.cmd_index, bus.cmd_data};
    assign {w_head_type, w_head_field, w_head_index, w_head_data} = w_head;

    vga_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clr   (clr),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    assign w_win         = win_open(vid_rd, vid_blank, BLANK_ONLY);
    assign bus.cmd_stall = bus.cmd_valid & w_full;
    assign bus.tbl_we    = (r_state == ST_WRITE);
    assign bus.tbl_sel   = r_sel;
    assign bus.tbl_addr  = r_addr;
    assign bus.tbl_wdata = r_wdata;
    assign busy          = ~w_empty | (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // WRITE always falls back to IDLE, which guarantees one idle cycle
    // between writes. A clear during WRITE lets the granted write finish;
    // its pop is dropped inside the FIFO because the queue is already empty.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !clr) begin
                    w_state_nxt = w_win ? ST_WRITE : ST_WAIT;
                    w_load      = w_win;
                end
            end
            ST_WAIT: begin
                if (clr) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_win) begin
                    w_state_nxt = ST_WRITE;
                    w_load      = 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.tbl_gnt) begin
                    w_state_nxt = ST_IDLE;
                    w_pop       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write fields are captured on entry to WRITE and held until the grant,
    // so they stay stable even if the window closes mid-request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel   <= SEL_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_sel   <= tbl_sel_of(w_head_type);
            r_addr  <= {w_head_index, field_code(w_head_field)};
            r_wdata <= w_head_data;
        end
    end
endmodule

// File: tb/tb_vga_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_vga_cmd_sched
// Directed testbench for vga_cmd_sched (DEPTH=4, IDX_W=6). Inputs are driven
// and outputs sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_vga_cmd_sched;
    import vga_cmd_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDX_W = 6;

    logic                   clk       = 1'b0;
    logic                   reset     = 1'b0;
    logic                   clr       = 1'b0;
    logic                   vid_rd    = 1'b0;
    logic                   vid_blank = 1'b1;
    logic                   busy;
    logic [$clog2(DEPTH):0] q_count;

    int n_checks = 0;
    int n_errors = 0;

    vga_cmd_sched_if #(.IDX_W(IDX_W)) bus ();

    vga_cmd_sched #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .clr       (clr),
        .vid_rd    (vid_rd),
        .vid_blank (vid_blank),
        .busy      (busy),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] t, input logic [2:0] f,
                            input logic [IDX_W-1:0] idx, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_field = f;
        bus.cmd_index = idx;
        bus.cmd_data  = d;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a write request, checks it, then grants it.
    task automatic expect_write(input string tag, input logic [2:0] sel,
                                input logic [IDX_W+1:0] addr, input logic [31:0] data);
        int n = 0;
        while (bus.tbl_we !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_we"},    64'(bus.tbl_we),    64'd1);
        check({tag, "_sel"},   64'(bus.tbl_sel),   64'(sel));
        check({tag, "_addr"},  64'(bus.tbl_addr),  64'(addr));
        check({tag, "_wdata"}, 64'(bus.tbl_wdata), 64'(data));
        bus.tbl_gnt = 1'b1;
        step();
        bus.tbl_gnt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with cmd_valid high: stall must stay low, nothing enqueued.
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = CMD_SPRITE;
        bus.cmd_field = 3'b100;
        bus.cmd_index = '0;
        bus.cmd_data  = '0;
        bus.tbl_gnt   = 1'b0;
        #22;
        check("rst_we",    64'(bus.tbl_we),    64'd0);
        check("rst_qcnt",  64'(q_count),       64'd0);
        check("rst_busy",  64'(busy),          64'd0);
        check("rst_stall", 64'(bus.cmd_stall), 64'd0);
        check("rst_sel",   64'(bus.tbl_sel),   64'd0);
        check("rst_addr",  64'(bus.tbl_addr),  64'd0);
        check("rst_wdata", 64'(bus.tbl_wdata), 64'd0);
        bus.cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Single sprite write: pos, index 5 -> addr {5,00} = 0x14.
        bus.tbl_gnt = 1'b1;
        push_cmd(CMD_SPRITE, 3'b100, 6'd5, 32'h0012_0034);
        check("s1_qcnt_push", 64'(q_count),       64'd1);
        check("s1_we_push",   64'(bus.tbl_we),    64'd0);
        step();
        check("s1_we",        64'(bus.tbl_we),    64'd1);
        check("s1_sel",       64'(bus.tbl_sel),   64'h1);
        check("s1_addr",      64'(bus.tbl_addr),  64'h14);
        check("s1_wdata",     64'(bus.tbl_wdata), 64'h0012_0034);
        check("s1_qcnt_wr",   64'(q_count),       64'd1);
        step();
        check("s1_qcnt_done", 64'(q_count),       64'd0);
        check("s1_we_done",   64'(bus.tbl_we),    64'd0);
        check("s1_busy_done", 64'(busy),          64'd0);
        bus.tbl_gnt = 1'b0;

        // Full queue: five back-to-back font/attr commands, no grant.
        bus.cmd_type  = CMD_FONT;
        bus.cmd_field = 3'b010;
        for (int i = 1; i <= 4; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_index = 6'(i);
            bus.cmd_data  = 32'h100 + 32'(i);
            step();
        end
        bus.cmd_index = 6'd5;
        bus.cmd_data  = 32'h105;
        #1;
        check("full_qcnt",   64'(q_count),       64'd4);
        check("full_stall",  64'(bus.cmd_stall), 64'd1);
        check("full_we",     64'(bus.tbl_we),    64'd1);
        check("full_addr",   64'(bus.tbl_addr),  64'h05);
        check("full_sel",    64'(bus.tbl_sel),   64'h2);
        step();
        check("full_hold",   64'(q_count),       64'd4);
        check("full_stall2", 64'(bus.cmd_stall), 64'd1);
        bus.tbl_gnt = 1'b1;
        step();
        bus.tbl_gnt = 1'b0;
        check("full_pop",    64'(q_count),       64'd3);
        check("full_unstall",64'(bus.cmd_stall), 64'd0);
        step();
        bus.cmd_valid = 1'b0;
        check("full_5th_in", 64'(q_count),       64'd4);
        for (int i = 2; i <= 5; i++)
            expect_write("order", SEL_FONT, {6'(i), 2'b01}, 32'h100 + 32'(i));
        check("order_qcnt",  64'(q_count),       64'd0);
        check("order_busy",  64'(busy),          64'd0);

        // Window blocking: background/visi, index 10 -> addr {10,10} = 0x2A.
        vid_rd = 1'b1;
        push_cmd(CMD_BG, 3'b001, 6'd10, 32'hDEAD_BEEF);
        check("blk_we_push", 64'(bus.tbl_we), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("blk_we",    64'(bus.tbl_we),   64'd0);
            check("blk_state", 64'(dut.r_state),  64'(ST_WAIT));
        end
        vid_rd = 1'b0;
        step();
        check("blk_we_open", 64'(bus.tbl_we),    64'd1);
        check("blk_sel",     64'(bus.tbl_sel),   64'h4);
        check("blk_addr",    64'(bus.tbl_addr),  64'h2A);
        check("blk_wdata",   64'(bus.tbl_wdata), 64'hDEAD_BEEF);
        bus.tbl_gnt = 1'b1;
        step();
        bus.tbl_gnt = 1'b0;
        check("blk_busy",    64'(busy),          64'd0);

        // Blank gating: window open on vid_rd, display not blanking.
        vid_blank = 1'b0;
        push_cmd(CMD_SPRITE, 3'b010, 6'd3, 32'h0000_0BAD);
        step();
`ifdef VGA_SCHED_BLANK_ONLY_EN
        check("blank_gate1", 64'(bus.tbl_we), 64'd0);
        step();
        check("blank_gate2", 64'(bus.tbl_we), 64'd0);
`else
        check("blank_gate1", 64'(bus.tbl_we), 64'd1);
        step();
        check("blank_gate2", 64'(bus.tbl_we), 64'd1);
`endif
        vid_blank = 1'b1;
        expect_write("blank", SEL_SPRITE, 8'h0D, 32'h0000_0BAD);

        // Reserved type dropped; field priority attr>visi and pos>all.
        push_cmd(CMD_RSVD, 3'b100, 6'd1, 32'h1);
        check("rsvd_qcnt", 64'(q_count), 64'd0);
        check("rsvd_busy", 64'(busy),    64'd0);
        push_cmd(CMD_SPRITE, 3'b011, 6'd2, 32'h22);
        expect_write("prio_attr", SEL_SPRITE, 8'h09, 32'h22);
        push_cmd(CMD_FONT, 3'b111, 6'd4, 32'h44);
        expect_write("prio_pos", SEL_FONT, 8'h10, 32'h44);

        // Clear mid-write: three sprites with no field flags (code 11).
        bus.cmd_type  = CMD_SPRITE;
        bus.cmd_field = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_index = 6'(7 + i);
            bus.cmd_data  = 32'h700 + 32'(i);
            step();
        end
        bus.cmd_valid = 1'b0;
        check("clr_qcnt_pre", 64'(q_count),      64'd3);
        check("clr_we_pre",   64'(bus.tbl_we),   64'd1);
        check("clr_addr_pre", 64'(bus.tbl_addr), 64'h1F);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_qcnt",     64'(q_count),      64'd0);
        check("clr_we_hold",  64'(bus.tbl_we),   64'd1);
        check("clr_addr",     64'(bus.tbl_addr), 64'h1F);
        check("clr_busy",     64'(busy),         64'd1);
        bus.tbl_gnt = 1'b1;
        step();
        bus.tbl_gnt = 1'b0;
        check("clr_we_done",  64'(bus.tbl_we),   64'd0);
        check("clr_qcnt_end", 64'(q_count),      64'd0);
        check("clr_busy_end", 64'(busy),         64'd0);
        repeat (4) step();
        check("clr_no_more",  64'(bus.tbl_we),   64'd0);

        // Asynchronous reset in the middle of a WRITE.
        push_cmd(CMD_FONT, 3'b100, 6'd9, 32'h99);
        step();
        check("arst_we_pre", 64'(bus.tbl_we), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_we",    64'(bus.tbl_we),    64'd0);
        check("arst_qcnt",  64'(q_count),       64'd0);
        check("arst_busy",  64'(busy),          64'd0);
        check("arst_state", 64'(dut.r_state),   64'(ST_IDLE));
        check("arst_sel",   64'(bus.tbl_sel),   64'd0);
        check("arst_addr",  64'(bus.tbl_addr),  64'd0);
        check("arst_wdata", 64'(bus.tbl_wdata), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("arst_after_we",   64'(bus.tbl_we), 64'd0);
        check("arst_after_busy", 64'(busy),       64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
